// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline forwarding, stall/flush control and mult/div busy sequencer.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int MD_LATENCY = 32,
  parameter int REG_BITS   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] write_reg_e,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                mem_to_reg_m,
  input  logic                branch_d,
  input  logic                pc_src_d,
  input  logic                md_start_e,
  input  logic                md_use_d,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                forward_a_d,
  output logic                forward_b_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                md_busy,
  output logic                md_done,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);

  md_state_t  state, state_next;
  logic [5:0] count, count_next;
  logic       lwstall, brstall, mdstall, stall;

  // A write to register 0 never creates a dependency.
  function automatic logic hit(input logic we, input logic [REG_BITS-1:0] dst,
                               input logic [REG_BITS-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
    if (hit(reg_write_m, write_reg_m, src))      return 2'b10;
    else if (hit(reg_write_w, write_reg_w, src)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 6'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: if (md_start_e) begin
        state_next = BUSY;
        count_next = MD_LOAD;
      end
      BUSY: begin
        if (count == 6'd0) state_next = DONE;
        else               count_next = count - 6'd1;
      end
      DONE: begin
        if (md_start_e) begin
          state_next = BUSY;
          count_next = MD_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_busy = ~reset && (state == BUSY);
    md_done = ~reset && (state == DONE);
    lwstall = hit(mem_to_reg_e, write_reg_e, rs_d) | hit(mem_to_reg_e, write_reg_e, rt_d);
    brstall = branch_d & (hit(reg_write_e, write_reg_e, rs_d) | hit(reg_write_e, write_reg_e, rt_d) |
                          hit(mem_to_reg_m, write_reg_m, rs_d) | hit(mem_to_reg_m, write_reg_m, rt_d));
    mdstall = md_busy & md_use_d;
    stall   = ~reset & (lwstall | brstall | mdstall);
    stall_f = stall;
    stall_d = stall;
    flush_e = reset | stall;
    flush_d = reset | (pc_src_d & ~stall);
    forward_a_e = reset ? 2'b00 : fwd_sel(rs_e);
    forward_b_e = reset ? 2'b00 : fwd_sel(rt_e);
    forward_a_d = ~reset & hit(reg_write_m, write_reg_m, rs_d);
    forward_b_d = ~reset & hit(reg_write_m, write_reg_m, rt_d);
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (stall_d && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((flush_d || flush_e) && (flush_cycles != 32'hFFFF_FFFF))
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - randomized and directed bench for hazard_sequencer against a reference model.
module tb_hazard_sequencer;
  localparam int RB  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [RB-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic          reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic          branch_d, pc_src_d, md_start_e, md_use_d;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          forward_a_d, forward_b_d, stall_f, stall_d, flush_d, flush_e, md_busy, md_done;
  logic [31:0]   stall_cycles, flush_cycles;

  hazard_sequencer #(.MD_LATENCY(LAT), .REG_BITS(RB)) dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .branch_d(branch_d),
    .pc_src_d(pc_src_d), .md_start_e(md_start_e), .md_use_d(md_use_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .forward_a_d(forward_a_d),
    .forward_b_d(forward_b_d), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  int     checks = 0;
  int     errors = 0;
  int     busy_left = 0;
  bit     done_q = 1'b0;
  longint perf_stall = 0;
  longint perf_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input logic we, input logic [RB-1:0] dst, input logic [RB-1:0] src);
    return we && (dst != 0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [RB-1:0] src);
    if (dep(reg_write_m, write_reg_m, src)) return 2'd2;
    if (dep(reg_write_w, write_reg_w, src)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    reset = 0; rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0; mem_to_reg_e = 0; mem_to_reg_m = 0;
    branch_d = 0; pc_src_d = 0; md_start_e = 0; md_use_d = 0;
  endtask

  // Called with inputs freshly driven after a falling edge; checks, clocks the model, returns at the next falling edge.
  task automatic cycle();
    bit lw, br, stall, fl_d, fl_e, busy;
    logic [31:0] exp_sc, exp_fc;
    busy  = !reset && (busy_left > 0);
    lw    = dep(mem_to_reg_e, write_reg_e, rs_d) || dep(mem_to_reg_e, write_reg_e, rt_d);
    br    = branch_d && (dep(reg_write_e, write_reg_e, rs_d) || dep(reg_write_e, write_reg_e, rt_d) ||
                         dep(mem_to_reg_m, write_reg_m, rs_d) || dep(mem_to_reg_m, write_reg_m, rt_d));
    stall = !reset && (lw || br || (busy && md_use_d));
    fl_e  = reset || stall;
    fl_d  = reset || (pc_src_d && !stall);
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = perf_stall[31:0];
    exp_fc = perf_flush[31:0];
`else
    exp_sc = 0;
    exp_fc = 0;
`endif
    #1;
    check("forward_a_e", forward_a_e, reset ? 2'd0 : fwd_ref(rs_e));
    check("forward_b_e", forward_b_e, reset ? 2'd0 : fwd_ref(rt_e));
    check("forward_a_d", forward_a_d, !reset && dep(reg_write_m, write_reg_m, rs_d));
    check("forward_b_d", forward_b_d, !reset && dep(reg_write_m, write_reg_m, rt_d));
    check("stall_f", stall_f, stall);
    check("stall_d", stall_d, stall);
    check("flush_e", flush_e, fl_e);
    check("flush_d", flush_d, fl_d);
    check("md_busy", md_busy, busy);
    check("md_done", md_done, !reset && done_q);
    check("stall_cycles", stall_cycles, exp_sc);
    check("flush_cycles", flush_cycles, exp_fc);
    @(posedge clk);
    if (reset) begin
      busy_left = 0; done_q = 0; perf_stall = 0; perf_flush = 0;
    end else begin
      if (stall && perf_stall < 64'hFFFF_FFFF) perf_stall++;
      if ((fl_d || fl_e) && perf_flush < 64'hFFFF_FFFF) perf_flush++;
      if (busy_left > 0) begin
        busy_left--;
        done_q = (busy_left == 0);
      end else begin
        done_q = 0;
        if (md_start_e) busy_left = LAT;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(negedge clk);
    cycle();
    check("reset_flush_d", flush_d, 1'b1);
    check("reset_stall_d", stall_d, 1'b0);
    cycle();
    reset = 0;

    // Forwarding priority: M beats W; W used when M writes register 0.
    write_reg_m = 8; reg_write_m = 1; write_reg_w = 8; reg_write_w = 1; rs_e = 8;
    #1 check("fwd_m_prio", forward_a_e, 2'b10);
    cycle();
    write_reg_m = 0;
    #1 check("fwd_w_sel", forward_a_e, 2'b01);
    cycle();

    // Load-use stall, and none when the load targets register 0.
    clear_inputs();
    mem_to_reg_e = 1; write_reg_e = 9; rt_d = 9;
    #1 check("lw_stall_f", stall_f, 1'b1);
    check("lw_flush_e", flush_e, 1'b1);
    cycle();
    write_reg_e = 0;
    #1 check("lw_r0_nostall", stall_d, 1'b0);
    cycle();

    // Branch stall suppresses the taken-branch flush.
    clear_inputs();
    branch_d = 1; reg_write_e = 1; write_reg_e = 4; rs_d = 4; pc_src_d = 1;
    #1 check("br_stall_d", stall_d, 1'b1);
    check("br_no_flush_d", flush_d, 1'b0);
    cycle();

    // Mult/div: 4 busy cycles with stall, then one done cycle.
    clear_inputs();
    md_use_d = 1; md_start_e = 1;
    cycle();
    md_start_e = 0;
    for (int i = 0; i < LAT; i++) begin
      #1 check("md_busy_win", md_busy, 1'b1);
      check("md_stall_win", stall_d, 1'b1);
      cycle();
    end
    #1 check("md_done_pulse", md_done, 1'b1);
    check("md_stall_after", stall_d, 1'b0);
    cycle();
    check("md_idle", md_busy | md_done, 1'b0);
    cycle();

    // Reset during the second busy cycle, then a fresh issue.
    md_start_e = 1;
    cycle();
    md_start_e = 0;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    #1 check("md_reset_abort", md_busy, 1'b0);
    md_start_e = 1;
    cycle();
    md_start_e = 0;
    for (int i = 0; i < LAT; i++) begin
      #1 check("md_reissue_busy", md_busy, 1'b1);
      cycle();
    end
    #1 check("md_reissue_done", md_done, 1'b1);
    cycle();

    // Performance counters: 3 stall cycles, then 2 flush_d cycles.
    clear_inputs();
    reset = 1;
    cycle();
    reset = 0;
    mem_to_reg_e = 1; write_reg_e = 9; rt_d = 9;
    repeat (3) cycle();
    clear_inputs();
    pc_src_d = 1;
    repeat (2) cycle();
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    #1 check("perf_stall_3", stall_cycles, 32'd3);
    check("perf_flush_5", flush_cycles, 32'd5);
`else
    #1 check("perf_stall_off", stall_cycles, 32'd0);
    check("perf_flush_off", flush_cycles, 32'd0);
`endif
    cycle();

    // Randomized traffic on a small register range to provoke dependencies.
    for (int n = 0; n < 800; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      rs_d         = RB'($urandom_range(0, 3));
      rt_d         = RB'($urandom_range(0, 3));
      rs_e         = RB'($urandom_range(0, 3));
      rt_e         = RB'($urandom_range(0, 3));
      write_reg_e  = RB'($urandom_range(0, 3));
      write_reg_m  = RB'($urandom_range(0, 3));
      write_reg_w  = RB'($urandom_range(0, 3));
      reg_write_e  = 1'($urandom);
      reg_write_m  = 1'($urandom);
      reg_write_w  = 1'($urandom);
      mem_to_reg_e = ($urandom_range(0, 3) == 0);
      mem_to_reg_m = ($urandom_range(0, 3) == 0);
      branch_d     = 1'($urandom);
      pc_src_d     = 1'($urandom);
      md_start_e   = ($urandom_range(0, 7) == 0);
      md_use_d     = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
